// File: rtl/mouse_mmio_regs.sv
// PS/2 mouse packet assembler with memory-mapped status/posX/posY registers.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// WAIT_B0  | idle, waiting for a header byte (bit3 set); idle timer held at 0
// WAIT_B1  | header stored, waiting for the X delta byte
// WAIT_B2  | X delta stored, waiting for the Y delta byte (commit on arrival)
module mouse_mmio_regs #(
  parameter int BASE_ADDR   = 16384,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int X_INIT      = 195,
  parameter int Y_INIT      = 155,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        rd_en,
  input  logic [15:0] rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_hit,
  output logic        pkt_done,
  output logic        sync_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  // Timer reloads to TIMEOUT_CYC-1 on each accepted byte and expires on the
  // idle cycle that would bring an equivalent up-count to TIMEOUT_CYC.
  localparam logic [CW-1:0]      IDLE_LOAD = CW'(TIMEOUT_CYC - 1);
  localparam logic signed [16:0] X_MAX_S   = 17'(X_MAX);
  localparam logic signed [16:0] Y_MAX_S   = 17'(Y_MAX);
  localparam logic [15:0]        BASE      = 16'(BASE_ADDR);

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

  state_t          state;
  logic            x_ovf, y_ovf, x_sign, y_sign;
  logic [2:0]      btn_pend;
  logic [7:0]      b1;
  logic [15:0]     pos_x, pos_y;
  logic [2:0]      buttons;
  logic            new_flag;
  logic [CW-1:0]   idle_cnt;

  logic signed [16:0] dx, dy, nx, ny;
  logic [15:0]        nx_clamp, ny_clamp;
  logic [15:0]        rd_off;
  logic               rd_sel, status_rd;
  logic [15:0]        status_word;

  // Packet decode and clamped next position; b2 is taken straight from byte_in.
  always_comb begin
    dx = x_ovf ? '0 : {{8{x_sign}}, x_sign, b1};
    dy = y_ovf ? '0 : {{8{y_sign}}, y_sign, byte_in};
    nx = $signed({1'b0, pos_x}) + dx;
    ny = $signed({1'b0, pos_y}) - dy;
    if (nx < 0)             nx_clamp = '0;
    else if (nx > X_MAX_S)  nx_clamp = X_MAX_S[15:0];
    else                    nx_clamp = nx[15:0];
    if (ny < 0)             ny_clamp = '0;
    else if (ny > Y_MAX_S)  ny_clamp = Y_MAX_S[15:0];
    else                    ny_clamp = ny[15:0];
  end

  // Read address decode; out-of-window addresses wrap to large offsets.
  always_comb begin
    rd_off      = rd_addr - BASE;
    rd_sel      = rd_en && (rd_off < 16'd3);
    status_rd   = rd_sel && (rd_off == 16'd0);
    status_word = {12'b0, new_flag, buttons};
  end

  // Packet FSM, idle timer, position/button registers and event pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= WAIT_B0;
      x_ovf    <= 1'b0;
      y_ovf    <= 1'b0;
      x_sign   <= 1'b0;
      y_sign   <= 1'b0;
      btn_pend <= '0;
      b1       <= '0;
      pos_x    <= 16'(X_INIT);
      pos_y    <= 16'(Y_INIT);
      buttons  <= '0;
      new_flag <= 1'b0;
      idle_cnt <= '0;
      pkt_done <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      sync_err <= 1'b0;
      // Status read clears the flag; a commit below in the same cycle wins.
      if (status_rd) new_flag <= 1'b0;
      case (state)
        WAIT_B0: begin
          idle_cnt <= '0;
          if (byte_valid) begin
            if (byte_in[3]) begin
              y_ovf    <= byte_in[7];
              x_ovf    <= byte_in[6];
              y_sign   <= byte_in[5];
              x_sign   <= byte_in[4];
              btn_pend <= byte_in[2:0];
              idle_cnt <= IDLE_LOAD;
              state    <= WAIT_B1;
            end else begin
              sync_err <= 1'b1;
            end
          end
        end
        WAIT_B1: begin
          if (byte_valid) begin
            b1       <= byte_in;
            idle_cnt <= IDLE_LOAD;
            state    <= WAIT_B2;
          end else if (idle_cnt == '0) begin
            sync_err <= 1'b1;
            state    <= WAIT_B0;
          end else begin
            idle_cnt <= idle_cnt - 1'b1;
          end
        end
        WAIT_B2: begin
          if (byte_valid) begin
            pos_x    <= nx_clamp;
            pos_y    <= ny_clamp;
            buttons  <= btn_pend;
            new_flag <= 1'b1;
            pkt_done <= 1'b1;
            idle_cnt <= '0;
            state    <= WAIT_B0;
          end else if (idle_cnt == '0) begin
            sync_err <= 1'b1;
            state    <= WAIT_B0;
          end else begin
            idle_cnt <= idle_cnt - 1'b1;
          end
        end
        default: begin
          idle_cnt <= '0;
          state    <= WAIT_B0;
        end
      endcase
    end
  end

  // Registered read port; reports pre-commit values for a coincident commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
      rd_hit  <= 1'b0;
    end else if (rd_sel) begin
      rd_hit <= 1'b1;
      case (rd_off[1:0])
        2'd0:    rd_data <= status_word;
        2'd1:    rd_data <= pos_x;
        default: rd_data <= pos_y;
      endcase
    end else begin
      rd_data <= '0;
      rd_hit  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mouse_mmio_regs.sv
// Directed self-checking bench for mouse_mmio_regs.
module tb_mouse_mmio_regs;

  localparam int T = 100;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [15:0] rd_data;
  logic        rd_hit;
  logic        pkt_done;
  logic        sync_err;

  int n_pass = 0;
  int n_total = 0;

  mouse_mmio_regs #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_hit(rd_hit),
    .pkt_done(pkt_done), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic do_read(input logic [15:0] a);
    rd_en = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [15:0] addrs [5];
    logic [15:0] exp_d [5];
    logic        exp_h [5];
    addrs = '{16'd16384, 16'd16385, 16'd16386, 16'd16387, 16'd16383};
    exp_d = '{16'h0000, 16'd195, 16'd155, 16'd0, 16'd0};
    exp_h = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset();
    n_total++;
    if ({pkt_done, sync_err, rd_hit, rd_data} !== 19'd0)
      $display("FAIL reset_outputs got pd=%b se=%b hit=%b data=%0d want all 0", pkt_done, sync_err, rd_hit, rd_data);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      do_read(addrs[i]);
      n_total++;
      if (rd_hit !== exp_h[i] || rd_data !== exp_d[i])
        $display("FAIL reset_read addr=%0d got hit=%b data=%0d want hit=%b data=%0d", addrs[i], rd_hit, rd_data, exp_h[i], exp_d[i]);
      else n_pass++;
    end
  endtask

  task automatic test_packet_basic();
    apply_reset();
    send_byte(8'h09);
    send_byte(8'h0A);
    n_total++;
    if (pkt_done !== 1'b0) $display("FAIL early_pkt_done got %b want 0", pkt_done);
    else n_pass++;
    send_byte(8'h05);
    n_total++;
    if (pkt_done !== 1'b1) $display("FAIL pkt_done_pulse got %b want 1", pkt_done);
    else n_pass++;
    do_read(16'd16385);
    n_total++;
    if (rd_data !== 16'd205 || pkt_done !== 1'b0)
      $display("FAIL basic_posx got %0d pd=%b want 205 pd=0", rd_data, pkt_done);
    else n_pass++;
    do_read(16'd16386);
    n_total++;
    if (rd_data !== 16'd150) $display("FAIL basic_posy got %0d want 150", rd_data);
    else n_pass++;
    do_read(16'd16384);
    n_total++;
    if (rd_data !== 16'h0009) $display("FAIL basic_status got %h want 0009", rd_data);
    else n_pass++;
    do_read(16'd16384);
    n_total++;
    if (rd_data !== 16'h0001) $display("FAIL status_reread got %h want 0001", rd_data);
    else n_pass++;
  endtask

  task automatic test_clamp_low();
    apply_reset();
    send_pkt(8'h38, 8'h00, 8'hFF);
    do_read(16'd16385);
    n_total++;
    if (rd_data !== 16'd0) $display("FAIL clamp_x0 got %0d want 0", rd_data);
    else n_pass++;
    do_read(16'd16386);
    n_total++;
    if (rd_data !== 16'd156) $display("FAIL neg_dy_posy got %0d want 156", rd_data);
    else n_pass++;
    do_read(16'd16384);
    n_total++;
    if (rd_data !== 16'h0008) $display("FAIL clamp_status got %h want 0008", rd_data);
    else n_pass++;
  endtask

  task automatic test_overflow();
    apply_reset();
    send_pkt(8'h48, 8'h7F, 8'h10);
    do_read(16'd16385);
    n_total++;
    if (rd_data !== 16'd195) $display("FAIL xovf_posx got %0d want 195", rd_data);
    else n_pass++;
    do_read(16'd16386);
    n_total++;
    if (rd_data !== 16'd139) $display("FAIL xovf_posy got %0d want 139", rd_data);
    else n_pass++;
    send_pkt(8'h88, 8'h05, 8'h7F);
    do_read(16'd16385);
    n_total++;
    if (rd_data !== 16'd200) $display("FAIL yovf_posx got %0d want 200", rd_data);
    else n_pass++;
    do_read(16'd16386);
    n_total++;
    if (rd_data !== 16'd139) $display("FAIL yovf_posy got %0d want 139", rd_data);
    else n_pass++;
  endtask

  task automatic test_clamp_high();
    apply_reset();
    send_pkt(8'h08, 8'hFF, 8'h00);
    do_read(16'd16385);
    n_total++;
    if (rd_data !== 16'd450) $display("FAIL x_step got %0d want 450", rd_data);
    else n_pass++;
    send_pkt(8'h08, 8'hFF, 8'h00);
    do_read(16'd16385);
    n_total++;
    if (rd_data !== 16'd639) $display("FAIL clamp_xmax got %0d want 639", rd_data);
    else n_pass++;
    send_pkt(8'h28, 8'h00, 8'h00);
    do_read(16'd16386);
    n_total++;
    if (rd_data !== 16'd411) $display("FAIL y_step got %0d want 411", rd_data);
    else n_pass++;
    send_pkt(8'h28, 8'h00, 8'h00);
    do_read(16'd16386);
    n_total++;
    if (rd_data !== 16'd479) $display("FAIL clamp_ymax got %0d want 479", rd_data);
    else n_pass++;
    send_pkt(8'h08, 8'h00, 8'hFF);
    send_pkt(8'h08, 8'h00, 8'hFF);
    do_read(16'd16386);
    n_total++;
    if (rd_data !== 16'd0) $display("FAIL clamp_y0 got %0d want 0", rd_data);
    else n_pass++;
    do_read(16'd16385);
    n_total++;
    if (rd_data !== 16'd639) $display("FAIL xmax_hold got %0d want 639", rd_data);
    else n_pass++;
  endtask

  task automatic test_sync();
    apply_reset();
    send_byte(8'h05);
    n_total++;
    if (sync_err !== 1'b1) $display("FAIL discard_sync_err got %b want 1", sync_err);
    else n_pass++;
    tick();
    n_total++;
    if (sync_err !== 1'b0) $display("FAIL sync_err_width got %b want 0", sync_err);
    else n_pass++;
    send_byte(8'h08);
    send_byte(8'h03);
    repeat (T - 1) tick();
    n_total++;
    if (sync_err !== 1'b0) $display("FAIL early_timeout got %b want 0", sync_err);
    else n_pass++;
    tick();
    n_total++;
    if (sync_err !== 1'b1) $display("FAIL timeout_sync_err got %b want 1", sync_err);
    else n_pass++;
    do_read(16'd16385);
    n_total++;
    if (rd_data !== 16'd195 || sync_err !== 1'b0)
      $display("FAIL timeout_posx got %0d se=%b want 195 se=0", rd_data, sync_err);
    else n_pass++;
    send_pkt(8'h08, 8'h01, 8'h01);
    n_total++;
    if (pkt_done !== 1'b1) $display("FAIL resync_pkt_done got %b want 1", pkt_done);
    else n_pass++;
    do_read(16'd16385);
    n_total++;
    if (rd_data !== 16'd196) $display("FAIL resync_posx got %0d want 196", rd_data);
    else n_pass++;
    do_read(16'd16386);
    n_total++;
    if (rd_data !== 16'd154) $display("FAIL resync_posy got %0d want 154", rd_data);
    else n_pass++;
    send_byte(8'h08);
    repeat (T - 1) tick();
    send_byte(8'h02);
    n_total++;
    if (sync_err !== 1'b0) $display("FAIL expiry_byte_wins got %b want 0", sync_err);
    else n_pass++;
    send_byte(8'h00);
    do_read(16'd16385);
    n_total++;
    if (rd_data !== 16'd198) $display("FAIL expiry_posx got %0d want 198", rd_data);
    else n_pass++;
  endtask

  task automatic test_read_commit();
    apply_reset();
    send_pkt(8'h09, 8'h04, 8'h00);
    send_byte(8'h0A);
    send_byte(8'h04);
    rd_en = 1'b1;
    rd_addr = 16'd16384;
    byte_in = 8'h00;
    byte_valid = 1'b1;
    tick();
    rd_en = 1'b0;
    byte_valid = 1'b0;
    n_total++;
    if (rd_data !== 16'h0009 || pkt_done !== 1'b1)
      $display("FAIL coincident_read got %h pd=%b want 0009 pd=1", rd_data, pkt_done);
    else n_pass++;
    do_read(16'd16384);
    n_total++;
    if (rd_data !== 16'h000A) $display("FAIL flag_set_wins got %h want 000a", rd_data);
    else n_pass++;
    do_read(16'd16384);
    n_total++;
    if (rd_data !== 16'h0002) $display("FAIL flag_cleared got %h want 0002", rd_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    rd_en = 1'b1;
    rd_addr = 16'd16385;
    send_byte(8'h08);
    send_byte(8'h10);
    n_total++;
    if (rd_data !== 16'd203 || rd_hit !== 1'b1)
      $display("FAIL pre_reset_posx got %0d hit=%b want 203 hit=1", rd_data, rd_hit);
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_total++;
    if (rd_data !== 16'd0 || rd_hit !== 1'b0)
      $display("FAIL async_reset got %0d hit=%b want 0 hit=0", rd_data, rd_hit);
    else n_pass++;
    #1;
    rst = 1'b1;
    rd_en = 1'b0;
    send_byte(8'h10);
    n_total++;
    if (sync_err !== 1'b1 || pkt_done !== 1'b0)
      $display("FAIL post_reset_b2 got se=%b pd=%b want se=1 pd=0", sync_err, pkt_done);
    else n_pass++;
    do_read(16'd16385);
    n_total++;
    if (rd_data !== 16'd195) $display("FAIL post_reset_posx got %0d want 195", rd_data);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    byte_in = 8'h00;
    byte_valid = 1'b0;
    rd_en = 1'b0;
    rd_addr = 16'd0;
    test_reset();
    test_packet_basic();
    test_clamp_low();
    test_overflow();
    test_clamp_high();
    test_sync();
    test_read_commit();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
